// File: rtl/mc_pipe_reg.sv
// Elastic pipeline register: DEPTH valid/ready stages with bubble collapse,
// flush and registered occupancy count.
module mc_pipe_reg #(
    parameter int unsigned            WIDTH       = 32,
    parameter int unsigned            DEPTH       = 2,
    parameter logic [WIDTH-1:0]       RESET_VALUE = '0,
    localparam int unsigned           CW          = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
);

    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [DEPTH-1:0] adv;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             rdy;
    logic             push;

    // Ready ripples from the consumer back to stage 0; flush blocks every move.
    always_comb begin
        adv = '0;
        rdy = out_ready & ~flush;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            adv[i] = v_q[i] & rdy;
            rdy    = (~v_q[i] | adv[i]) & ~flush;
        end
    end

    assign in_ready  = rdy & ~rst;
    assign push      = in_valid & in_ready;
    assign out_valid = v_q[DEPTH-1] & ~flush;
    assign out_data  = d_q[DEPTH-1];
    assign count     = cnt_q;

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (adv[i]) v_d[i] = 1'b0;
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (adv[i-1]) begin
                v_d[i] = 1'b1;
                d_d[i] = d_q[i-1];
            end
        end
        if (push) begin
            v_d[0] = 1'b1;
            d_d[0] = in_data;
        end
        cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_d = cnt_d + CW'(v_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) d_q[i] <= RESET_VALUE;
        end else if (flush) begin
            v_q   <= '0;
            cnt_q <= '0;
        end else begin
            v_q   <= v_d;
            cnt_q <= cnt_d;
            d_q   <= d_d;
        end
    end

endmodule

// File: tb/tb_mc_pipe_reg.sv
// Bench for mc_pipe_reg: DEPTH=3 and DEPTH=1 instances against a queue model
// where a word is visible once its age reaches DEPTH-1 and it heads the queue.
module tb_mc_pipe_reg;

    localparam logic [31:0] RV3 = 32'hDEAD_BEEF;
    localparam logic [31:0] RV1 = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_data;
    logic        ir3, ov3, ir1, ov1;
    logic [31:0] od3, od1;
    logic [1:0]  c3;
    logic [0:0]  c1;

    always #5 clk = ~clk;

    mc_pipe_reg #(.WIDTH(32), .DEPTH(3), .RESET_VALUE(RV3)) u3 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir3), .in_data(in_data),
        .out_valid(ov3), .out_ready(out_ready), .out_data(od3),
        .count(c3)
    );

    mc_pipe_reg #(.WIDTH(32), .DEPTH(1), .RESET_VALUE(RV1)) u1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
        .count(c1)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    longint      cyc    = 0;
    logic [31:0] q3d[$];
    logic [31:0] q1d[$];
    longint      q3t[$];
    longint      q1t[$];
    logic [31:0] last3  = RV3;
    logic [31:0] last1  = RV1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic f, input logic iv,
                        input logic [31:0] id, input logic ordy,
                        output bit acc);
        bit raw3, raw1, e_ov3, e_ov1, e_ir3, e_ir1;
        @(negedge clk);
        rst = r; flush = f; in_valid = iv; in_data = id; out_ready = ordy;
        #1;
        raw3 = q3d.size() > 0 && (cyc - q3t[0]) >= 2;
        raw1 = q1d.size() > 0;
        if (raw3) last3 = q3d[0];
        if (raw1) last1 = q1d[0];
        e_ov3 = raw3 && !f;
        e_ov1 = raw1 && !f;
        e_ir3 = !f && !r &&
                (q3d.size() < 3 || (e_ov3 && ordy));
        e_ir1 = !f && !r &&
                (q1d.size() < 1 || (e_ov1 && ordy));
        if (!r) begin
            chk("in_ready3",  32'(ir3), 32'(e_ir3));
            chk("out_valid3", 32'(ov3), 32'(e_ov3));
            chk("out_data3",  od3, last3);
            chk("count3",     32'(c3), 32'(q3d.size()));
            chk("in_ready1",  32'(ir1), 32'(e_ir1));
            chk("out_valid1", 32'(ov1), 32'(e_ov1));
            chk("out_data1",  od1, last1);
            chk("count1",     32'(c1), 32'(q1d.size()));
        end
        acc = iv && e_ir3;
        @(posedge clk);
        cyc++;
        if (r || f) begin
            q3d.delete(); q3t.delete();
            q1d.delete(); q1t.delete();
            if (r) begin
                last3 = RV3;
                last1 = RV1;
            end
        end else begin
            if (e_ov3 && ordy) begin
                void'(q3d.pop_front()); void'(q3t.pop_front());
            end
            if (iv && e_ir3) begin
                q3d.push_back(id); q3t.push_back(cyc);
            end
            if (e_ov1 && ordy) begin
                void'(q1d.pop_front()); void'(q1t.pop_front());
            end
            if (iv && e_ir1) begin
                q1d.push_back(id); q1t.push_back(cyc);
            end
        end
    endtask

    initial begin
        bit          acc;
        logic [31:0] w;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_data = '0; out_ready = 1'b0;

        step(1, 0, 0, 0, 0, acc);
        step(1, 0, 0, 0, 0, acc);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, acc);

        for (int k = 1; k <= 5; k++) step(0, 0, 1, 32'(k), 1, acc);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, acc);

        w = 32'hA0;
        for (int t = 0; t < 40 && w <= 32'hA4; t++) begin
            step(0, 0, 1, w, t >= 6, acc);
            if (acc) w++;
        end
        chk("bp_all_sent", w, 32'hA5);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, acc);

        step(0, 0, 1, 32'h0000_00AA, 0, acc);
        step(0, 0, 0, 0, 0, acc);
        step(0, 0, 1, 32'h0000_00BB, 0, acc);
        step(0, 0, 0, 0, 0, acc);
        step(0, 0, 0, 0, 0, acc);
        step(0, 0, 1, 32'h0000_00CC, 0, acc);
        step(0, 0, 1, 32'h0000_00DD, 1, acc);
        step(0, 1, 1, 32'h0000_00DD, 1, acc);
        step(0, 0, 1, 32'h0000_00EE, 1, acc);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, acc);

        step(0, 0, 1, 32'h1111_1111, 0, acc);
        step(0, 0, 1, 32'h2222_2222, 0, acc);
        step(0, 0, 0, 0, 0, acc);
        step(1, 0, 1, 32'h3333_3333, 1, acc);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, acc);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(63) == 0, $urandom_range(15) == 0,
                 $urandom_range(1) == 1, $urandom,
                 $urandom_range(9) < 6, acc);
        end
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, acc);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
